// File: rtl/dual_port_data_memory.sv
// Two-port word-addressed data memory: combinational reads, synchronous writes,
// synchronous reset that clears every word. Port 2 wins on a same-word write collision.
module dual_port_data_memory #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr_1,
    input  logic [WIDTH-1:0] data_1,
    input  logic             MemRead_1,
    input  logic             MemWrite_1,
    output logic [WIDTH-1:0] data_o1,
    input  logic [31:0]      addr_2,
    input  logic [WIDTH-1:0] data_2,
    input  logic             MemRead_2,
    input  logic             MemWrite_2,
    output logic [WIDTH-1:0] data_o2
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] AddrLimit = 32'(4 * DEPTH);

    logic [WIDTH-1:0] memory [DEPTH];

    logic            in_range_1, in_range_2;
    logic [IdxW-1:0] idx_1, idx_2;

    // The full address feeds the range check; only the word bits select the entry.
    assign in_range_1 = (addr_1 < AddrLimit);
    assign in_range_2 = (addr_2 < AddrLimit);
    assign idx_1      = addr_1[IdxW+1:2];
    assign idx_2      = addr_2[IdxW+1:2];

    always_comb begin
        data_o1 = '0;
        if (MemRead_1 && in_range_1) begin
            data_o1 = memory[idx_1];
        end
    end

    always_comb begin
        data_o2 = '0;
        if (MemRead_2 && in_range_2) begin
            data_o2 = memory[idx_2];
        end
    end

    // Port 2 is assigned last so it takes precedence on a same-word collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                memory[i] <= '0;
            end
        end else begin
            if (MemWrite_1 && in_range_1) begin
                memory[idx_1] <= data_1;
            end
            if (MemWrite_2 && in_range_2) begin
                memory[idx_2] <= data_2;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_data_memory.sv
// Self-checking bench for dual_port_data_memory: directed cases plus random traffic
// compared against a byte-address array model.
module tb_dual_port_data_memory;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_1, data_1, addr_2, data_2;
    logic        MemRead_1, MemWrite_1, MemRead_2, MemWrite_2;
    logic [31:0] data_o1, data_o2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dual_port_data_memory #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_1     (addr_1),
        .data_1     (data_1),
        .MemRead_1  (MemRead_1),
        .MemWrite_1 (MemWrite_1),
        .data_o1    (data_o1),
        .addr_2     (addr_2),
        .data_2     (data_2),
        .MemRead_2  (MemRead_2),
        .MemWrite_2 (MemWrite_2),
        .data_o2    (data_o2)
    );

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic rd);
        if (!rd || a >= 4 * DEPTH) return 32'd0;
        return ref_mem[a / 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic r,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic rd1, input logic wr1,
                         input logic [31:0] a2, input logic [31:0] d2,
                         input logic rd2, input logic wr2);
        rst = r;
        addr_1 = a1; data_1 = d1; MemRead_1 = rd1; MemWrite_1 = wr1;
        addr_2 = a2; data_2 = d2; MemRead_2 = rd2; MemWrite_2 = wr2;
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_o1"}, data_o1, ref_read(addr_1, MemRead_1));
        check({tag, "_o2"}, data_o2, ref_read(addr_2, MemRead_2));
    endtask

    // Advance one clock; model applies reset, then port 1, then port 2 writes.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        end else begin
            if (MemWrite_1 && addr_1 < 4 * DEPTH) ref_mem[addr_1 / 4] = data_1;
            if (MemWrite_2 && addr_2 < 4 * DEPTH) ref_mem[addr_2 / 4] = data_2;
        end
        @(negedge clk);
    endtask

    task automatic check_memory(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_mem%0d", tag, i), dut.memory[i], ref_mem[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        @(negedge clk);

        // Reset, then every word reads zero on both ports.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 32'(4 * i), 0, 1, 0, 32'(4 * i), 0, 1, 0);
            check($sformatf("rst_rd1_w%0d", i), data_o1, 32'd0);
            check($sformatf("rst_rd2_w%0d", i), data_o2, 32'd0);
        end

        // Write on port 1, read back on port 2.
        drive(0, 8, 5, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 8, 0, 1, 0);
        check("wr_rd_o2", data_o2, 32'd5);
        check("wr_rd_mem2", dut.memory[2], 32'd5);

        // Same-word collision: port 2 wins.
        drive(0, 12, 7, 0, 1, 12, 9, 0, 1);
        tick();
        check("collide_mem3", dut.memory[3], 32'd9);

        // Read-during-write returns old data.
        drive(0, 0, 3, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 32'hAAAA, 0, 1, 0, 0, 1, 0);
        check("rdw_old", data_o2, 32'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("rdw_new", data_o2, 32'hAAAA);

        // Same port read+write.
        drive(0, 16, 32'h1234, 1, 1, 0, 0, 0, 0);
        check("same_port_old", data_o1, 32'd0);
        tick();
        drive(0, 16, 0, 1, 0, 0, 0, 0, 0);
        check("same_port_new", data_o1, 32'h1234);

        // Out-of-range write ignored, disabled read gives zero.
        drive(0, 128, 1, 1, 1, 8, 0, 0, 0);
        check("oor_rd_o1", data_o1, 32'd0);
        check("rd_dis_o2", data_o2, 32'd0);
        tick();
        check_memory("oor");

        // Reset beats a same-cycle write; reads continue during reset.
        drive(1, 4, 6, 0, 1, 8, 7, 0, 1);
        tick();
        check("rst_prio_mem1", dut.memory[1], 32'd0);
        check("rst_prio_mem2", dut.memory[2], 32'd0);
        drive(1, 4, 0, 1, 0, 12, 0, 1, 0);
        check("rst_rd_o1", data_o1, 32'd0);
        check("rst_rd_o2", data_o2, 32'd0);
        tick();

        // Random traffic, including out-of-range addresses and occasional reset.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  32'($urandom_range(0, 159)), $urandom, 1'($urandom), 1'($urandom),
                  32'($urandom_range(0, 159)), $urandom, 1'($urandom), 1'($urandom));
            check_outputs($sformatf("rnd%0d", n));
            tick();
            if (n % 100 == 99) check_memory($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
